// File: rtl/ofdm_rx_sample_player.sv
// RAM-backed I/Q frame player feeding the OFDM RX input with strobe, repeat and gap control.
// Define OFDM_PLAYER_NOISE_EN to add a saturating LFSR noise floor to every strobe.
module ofdm_rx_sample_player #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int REPEAT_WIDTH = 8,
    parameter int GAP_WIDTH    = 16,
    parameter int STROBE_DIV   = 4
) (
    input  logic                           sys_clk,
    input  logic                           sys_rstn,
    input  logic                           sys_init,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic signed [SAMPLE_WIDTH-1:0] wr_i,
    input  logic signed [SAMPLE_WIDTH-1:0] wr_q,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            cfg_length,
    input  logic [REPEAT_WIDTH-1:0]        cfg_repeat,
    input  logic [GAP_WIDTH-1:0]           cfg_gap,
    output logic signed [SAMPLE_WIDTH-1:0] rx_data_i,
    output logic signed [SAMPLE_WIDTH-1:0] rx_data_q,
    output logic                           rx_data_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);

    localparam int DIV_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam int LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, PREFETCH, PLAY, GAP, FINISH} state_t;

    logic signed [SAMPLE_WIDTH-1:0] mem_i [DEPTH];
    logic signed [SAMPLE_WIDTH-1:0] mem_q [DEPTH];

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [LEN_W-1:0]        len_r, smp_cnt;
    logic [REPEAT_WIDTH-1:0] rep_r;
    logic [GAP_WIDTH-1:0]    gap_r, gap_cnt;

    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic signed [SAMPLE_WIDTH-1:0] raw_i, raw_q, smp_i, smp_q;
    logic issue, cfg_ok, frame_end, gap_end, last_frame;
    logic [DIV_W-1:0] div_next;

    assign issue = (div_cnt == '0) &&
                   (state == PREFETCH || state == PLAY || state == GAP);
    assign cfg_ok     = (cfg_length != '0) && (cfg_length <= LEN_W'(DEPTH));
    assign frame_end  = (smp_cnt + 1'b1) == len_r;
    assign gap_end    = (gap_cnt + 1'b1) == gap_r;
    assign last_frame = (rep_r == REPEAT_WIDTH'(1));
    assign div_next   = (div_cnt == DIV_W'(STROBE_DIV - 1)) ? '0 : div_cnt + 1'b1;
    assign rd_addr    = smp_cnt[ADDR_WIDTH-1:0];

    // Writes are locked out during playback so a frame is never torn.
    always_ff @(posedge sys_clk) begin
        if (wr_en && !busy && !sys_init) begin
            mem_i[wr_addr] <= wr_i;
            mem_q[wr_addr] <= wr_q;
        end
    end

    always_comb begin
        raw_i = '0;
        raw_q = '0;
        if (state != GAP) begin
            raw_i = mem_i[rd_addr];
            raw_q = mem_q[rd_addr];
        end
    end

`ifdef OFDM_PLAYER_NOISE_EN
    logic [15:0]                    lfsr;
    logic [SAMPLE_WIDTH-1:0]        lfsr_rev;
    logic signed [SAMPLE_WIDTH-1:0] nz_i, nz_q;

    function automatic logic signed [SAMPLE_WIDTH-1:0] sat_add(
        input logic signed [SAMPLE_WIDTH-1:0] a,
        input logic signed [SAMPLE_WIDTH-1:0] b
    );
        logic [SAMPLE_WIDTH:0] s;
        s = {a[SAMPLE_WIDTH-1], a} + {b[SAMPLE_WIDTH-1], b};
        if (s[SAMPLE_WIDTH] != s[SAMPLE_WIDTH-1])
            return s[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        return s[SAMPLE_WIDTH-1:0];
    endfunction

    always_comb begin
        lfsr_rev = '0;
        for (int b = 0; b < SAMPLE_WIDTH; b++)
            lfsr_rev[b] = lfsr[15-b];
        nz_i  = $signed(lfsr[SAMPLE_WIDTH-1:0]) >>> 4;
        nz_q  = $signed(lfsr_rev) >>> 4;
        smp_i = sat_add(raw_i, nz_i);
        smp_q = sat_add(raw_q, nz_q);
    end

    // x^16+x^14+x^13+x^11+1, shifting right; one step per emitted strobe.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn)
            lfsr <= 16'hACE1;
        else if (sys_init)
            lfsr <= 16'hACE1;
        else if (issue)
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`else
    assign smp_i = raw_i;
    assign smp_q = raw_q;
`endif

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state         <= IDLE;
            div_cnt       <= '0;
            len_r         <= '0;
            smp_cnt       <= '0;
            rep_r         <= '0;
            gap_r         <= '0;
            gap_cnt       <= '0;
            rx_data_i     <= '0;
            rx_data_q     <= '0;
            rx_data_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else if (sys_init) begin
            state         <= IDLE;
            div_cnt       <= '0;
            len_r         <= '0;
            smp_cnt       <= '0;
            rep_r         <= '0;
            gap_r         <= '0;
            gap_cnt       <= '0;
            rx_data_i     <= '0;
            rx_data_q     <= '0;
            rx_data_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            rx_data_i     <= '0;
            rx_data_q     <= '0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
            if (state == PREFETCH || state == PLAY || state == GAP)
                div_cnt <= div_next;
            unique case (state)
                IDLE: begin
                    if (start && cfg_ok) begin
                        len_r   <= cfg_length;
                        rep_r   <= cfg_repeat;
                        gap_r   <= cfg_gap;
                        smp_cnt <= '0;
                        gap_cnt <= '0;
                        div_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= PREFETCH;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                    end
                end
                PREFETCH, PLAY: begin
                    state <= PLAY;
                    if (issue) begin
                        rx_data_valid <= 1'b1;
                        rx_data_i     <= smp_i;
                        rx_data_q     <= smp_q;
                        smp_cnt       <= smp_cnt + 1'b1;
                        if (frame_end) begin
                            smp_cnt <= '0;
                            // rep_r == 0 stays 0: endless play
                            if (rep_r > REPEAT_WIDTH'(1))
                                rep_r <= rep_r - 1'b1;
                            if (last_frame) begin
                                state <= FINISH;
                            end else if (gap_r != '0) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (issue) begin
                        rx_data_valid <= 1'b1;
                        rx_data_i     <= smp_i;
                        rx_data_q     <= smp_q;
                        gap_cnt       <= gap_cnt + 1'b1;
                        if (gap_end)
                            state <= PLAY;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
